// File: rtl/data_if_router.sv
// Routes OBI-style core data requests to the data SRAM, the AXI master bridge or a local error
// responder, keeping only one target in flight at a time so responses return in request order.
module data_if_router #(
  parameter int unsigned MAX_OUTSTANDING = 2,
  // Address windows packed as {start, end}; start inclusive, end exclusive.
  parameter logic [63:0] SRAM_RULE = {32'h3000_0000, 32'h3000_2000},
  parameter logic [63:0] AXI_RULE  = {32'h4000_0000, 32'h7F00_0000}
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  output logic        core_gnt_o,
  input  logic [31:0] core_addr_i,
  input  logic        core_we_i,
  input  logic [3:0]  core_be_i,
  input  logic [31:0] core_wdata_i,
  output logic        core_rvalid_o,
  output logic [31:0] core_rdata_o,
  output logic        core_err_o,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  output logic        sram_req_o,
  output logic        axi_req_o,
  input  logic        sram_gnt_i,
  input  logic        axi_gnt_i,
  input  logic        sram_rvalid_i,
  input  logic        axi_rvalid_i,
  input  logic [31:0] sram_rdata_i,
  input  logic [31:0] axi_rdata_i,
  input  logic        sram_err_i,
  input  logic        axi_err_i
);

  typedef enum logic [1:0] {TGT_NONE, TGT_SRAM, TGT_AXI, TGT_ERR} tgt_e;

  localparam logic [31:0] SRAM_START = SRAM_RULE[63:32];
  localparam logic [31:0] SRAM_END   = SRAM_RULE[31:0];
  localparam logic [31:0] AXI_START  = AXI_RULE[63:32];
  localparam logic [31:0] AXI_END    = AXI_RULE[31:0];
  localparam logic [2:0]  MAX_CNT    = 3'(MAX_OUTSTANDING);

  tgt_e        w_sel;
  tgt_e        r_cur_tgt;
  logic [2:0]  r_cnt;
  logic        r_err_pend;
  logic        w_can_issue;
  logic        w_sram_req;
  logic        w_axi_req;
  logic        w_gnt;
  logic        w_rsp_valid;
  logic [31:0] w_rsp_rdata;
  logic        w_rsp_err;

  // SRAM is checked first so it wins if the two windows ever overlap.
  always_comb begin
    w_sel = TGT_ERR;
    if (core_addr_i >= SRAM_START && core_addr_i < SRAM_END) begin
      w_sel = TGT_SRAM;
    end else if (core_addr_i >= AXI_START && core_addr_i < AXI_END) begin
      w_sel = TGT_AXI;
    end
  end

  always_comb begin
    w_can_issue = (r_cnt < MAX_CNT) && ((r_cnt == 3'd0) || (w_sel == r_cur_tgt));
    w_sram_req  = core_req_i && w_can_issue && (w_sel == TGT_SRAM);
    w_axi_req   = core_req_i && w_can_issue && (w_sel == TGT_AXI);
    w_gnt       = (w_sram_req && sram_gnt_i) || (w_axi_req && axi_gnt_i) ||
                  (core_req_i && w_can_issue && (w_sel == TGT_ERR));
  end

  // Responses from anything other than the in-flight target are dropped.
  always_comb begin
    w_rsp_valid = 1'b0;
    w_rsp_rdata = '0;
    w_rsp_err   = 1'b0;
    if (r_cnt != 3'd0) begin
      case (r_cur_tgt)
        TGT_SRAM: begin
          if (sram_rvalid_i) begin
            w_rsp_valid = 1'b1;
            w_rsp_rdata = sram_rdata_i;
            w_rsp_err   = sram_err_i;
          end
        end
        TGT_AXI: begin
          if (axi_rvalid_i) begin
            w_rsp_valid = 1'b1;
            w_rsp_rdata = axi_rdata_i;
            w_rsp_err   = axi_err_i;
          end
        end
        TGT_ERR: begin
          w_rsp_valid = r_err_pend;
          w_rsp_err   = r_err_pend;
        end
        default: begin
          w_rsp_valid = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt      <= 3'd0;
      r_cur_tgt  <= TGT_NONE;
      r_err_pend <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_cur_tgt <= w_sel;
      end
      r_err_pend <= w_gnt && (w_sel == TGT_ERR);
      if (w_gnt && !w_rsp_valid) begin
        r_cnt <= r_cnt + 3'd1;
      end else if (!w_gnt && w_rsp_valid) begin
        r_cnt <= r_cnt - 3'd1;
      end
    end
  end

  assign m_addr_o      = core_addr_i;
  assign m_we_o        = core_we_i;
  assign m_be_o        = core_be_i;
  assign m_wdata_o     = core_wdata_i;
  assign sram_req_o    = rst_ni && w_sram_req;
  assign axi_req_o     = rst_ni && w_axi_req;
  assign core_gnt_o    = rst_ni && w_gnt;
  assign core_rvalid_o = rst_ni && w_rsp_valid;
  assign core_err_o    = rst_ni && w_rsp_err;
  assign core_rdata_o  = rst_ni ? w_rsp_rdata : 32'd0;

endmodule

// File: tb/tb_data_if_router.sv
// Scoreboard bench for data_if_router: random traffic against modelled SRAM/AXI targets,
// plus directed address-edge, stall and reset cases.
module tb_data_if_router;

  localparam int MAX = 2;
  localparam logic [31:0] SRAM_START = 32'h3000_0000;
  localparam logic [31:0] SRAM_END   = 32'h3000_2000;
  localparam logic [31:0] AXI_START  = 32'h4000_0000;
  localparam logic [31:0] AXI_END    = 32'h7F00_0000;

  typedef enum int {T_NONE, T_SRAM, T_AXI, T_ERR} tgt_t;
  typedef struct {
    logic [31:0] data;
    logic        err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        coreReq = 1'b0;
  logic [31:0] coreAddr = '0;
  logic        coreWe = 1'b0;
  logic [3:0]  coreBe = '0;
  logic [31:0] coreWdata = '0;
  logic        coreGnt, coreRvalid, coreErr;
  logic [31:0] coreRdata;
  logic [31:0] mAddr, mWdata;
  logic        mWe;
  logic [3:0]  mBe;
  logic        sramReq, axiReq;
  logic        sramGnt = 1'b0, axiGnt = 1'b0;
  logic        sramRvalid = 1'b0, axiRvalid = 1'b0;
  logic [31:0] sramRdata = '0, axiRdata = '0;
  logic        sramErr = 1'b0, axiErr = 1'b0;

  int checks = 0;
  int errors = 0;

  rsp_t sramQ[$];
  rsp_t axiQ[$];
  rsp_t sbQ[$];
  int          gntPct = 100;
  int          rspPct = 100;
  bit          forceEn = 1'b0;
  logic [31:0] forceData = '0;
  bit          forceErr = 1'b0;
  bit          lateInject = 1'b0;

  data_if_router #(.MAX_OUTSTANDING(MAX)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(coreReq), .core_gnt_o(coreGnt), .core_addr_i(coreAddr),
    .core_we_i(coreWe), .core_be_i(coreBe), .core_wdata_i(coreWdata),
    .core_rvalid_o(coreRvalid), .core_rdata_o(coreRdata), .core_err_o(coreErr),
    .m_addr_o(mAddr), .m_we_o(mWe), .m_be_o(mBe), .m_wdata_o(mWdata),
    .sram_req_o(sramReq), .axi_req_o(axiReq),
    .sram_gnt_i(sramGnt), .axi_gnt_i(axiGnt),
    .sram_rvalid_i(sramRvalid), .axi_rvalid_i(axiRvalid),
    .sram_rdata_i(sramRdata), .axi_rdata_i(axiRdata),
    .sram_err_i(sramErr), .axi_err_i(axiErr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic tgt_t decode(input logic [31:0] a);
    if (a >= SRAM_START && a < SRAM_END) return T_SRAM;
    if (a >= AXI_START && a < AXI_END) return T_AXI;
    return T_ERR;
  endfunction

  function automatic rsp_t mkRsp(input bit isAxi);
    rsp_t r;
    r.data = forceEn ? forceData : $urandom;
    r.err  = forceEn ? forceErr : (isAxi ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 7) == 0));
    return r;
  endfunction

  function automatic logic [31:0] randAddr();
    case ($urandom_range(0, 9))
      0, 1, 2, 3: return SRAM_START + 32'($urandom_range(0, 2047) * 4);
      4, 5, 6:    return AXI_START + (($urandom % (AXI_END - AXI_START)) & 32'hFFFF_FFFC);
      7:          return $urandom & 32'h0FFF_FFFC;
      8:          return 32'h8000_0000 | $urandom;
      default: begin
        case ($urandom_range(0, 5))
          0:       return 32'h3000_1FFC;
          1:       return 32'h3000_2000;
          2:       return 32'h3FFF_FFFC;
          3:       return 32'h4000_0000;
          4:       return 32'h7EFF_FFFC;
          default: return 32'h7F00_0000;
        endcase
      end
    endcase
  endfunction

  // Target models: accept on req&gnt, pick the response they will return, answer in order later.
  always @(negedge clk) begin
    rsp_t r;
    if (!rst_n) begin
      sramQ.delete();
      axiQ.delete();
    end else begin
      if (sramReq && sramGnt) begin
        r = mkRsp(1'b0);
        sramQ.push_back(r);
        sbQ.push_back(r);
      end
      if (axiReq && axiGnt) begin
        r = mkRsp(1'b1);
        axiQ.push_back(r);
        sbQ.push_back(r);
      end
    end
  end

  always @(posedge clk) begin
    rsp_t r;
    #1;
    sramGnt = ($urandom_range(0, 99) < gntPct);
    axiGnt  = ($urandom_range(0, 99) < gntPct);
    if (lateInject) begin
      sramRvalid = 1'b1;
      sramRdata  = 32'h1234_5678;
      sramErr    = 1'b1;
      axiRvalid  = 1'b0;
    end else begin
      if (sramQ.size() > 0 && $urandom_range(0, 99) < rspPct) begin
        r = sramQ.pop_front();
        sramRvalid = 1'b1; sramRdata = r.data; sramErr = r.err;
      end else begin
        sramRvalid = 1'b0; sramRdata = $urandom; sramErr = 1'($urandom);
      end
      if (axiQ.size() > 0 && $urandom_range(0, 99) < rspPct) begin
        r = axiQ.pop_front();
        axiRvalid = 1'b1; axiRdata = r.data; axiErr = r.err;
      end else begin
        axiRvalid = 1'b0; axiRdata = $urandom; axiErr = 1'($urandom);
      end
    end
  end

  // Reference model of issue rules: in-flight count and target, one-cycle local error reply.
  int   inflight = 0;
  tgt_t lastTgt = T_NONE;
  bit   errPendM = 1'b0;

  always @(negedge clk) begin
    tgt_t sel;
    bit allow, expS, expA, expG, respNow;
    if (!rst_n) begin
      checkOutput("reset ctrl outputs", 32'({coreGnt, sramReq, axiReq, coreRvalid, coreErr}), 32'd0);
      checkOutput("reset rdata", coreRdata, 32'd0);
      inflight = 0;
      lastTgt  = T_NONE;
      errPendM = 1'b0;
    end else begin
      sel   = decode(coreAddr);
      allow = (inflight < MAX) && (inflight == 0 || sel == lastTgt);
      expS  = coreReq && allow && sel == T_SRAM;
      expA  = coreReq && allow && sel == T_AXI;
      expG  = coreReq && allow && (sel == T_ERR || (sel == T_SRAM && sramGnt) || (sel == T_AXI && axiGnt));
      respNow = (inflight > 0) && ((lastTgt == T_SRAM && sramRvalid) ||
                                   (lastTgt == T_AXI && axiRvalid) ||
                                   (lastTgt == T_ERR && errPendM));
      checkOutput("sram_req", 32'(sramReq), 32'(expS));
      checkOutput("axi_req", 32'(axiReq), 32'(expA));
      checkOutput("core_gnt", 32'(coreGnt), 32'(expG));
      checkOutput("core_rvalid", 32'(coreRvalid), 32'(respNow));
      if (coreReq) begin
        checkOutput("m_addr copy", mAddr, coreAddr);
        checkOutput("m_ctrl copy", 32'({mWe, mBe}), 32'({coreWe, coreBe}));
        checkOutput("m_wdata copy", mWdata, coreWdata);
      end
      if (coreReq && coreGnt && sel == T_ERR) sbQ.push_back('{32'd0, 1'b1});
      inflight = inflight + int'(expG) - int'(respNow);
      if (expG) lastTgt = sel;
      errPendM = expG && (sel == T_ERR);
    end
  end

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    rsp_t e;
    if (!rst_n) begin
      sbQ.delete();
    end else if (coreRvalid) begin
      if (sbQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected rvalid: got rvalid=1 rdata=0x%08h, required no response", coreRdata);
      end else begin
        e = sbQ.pop_front();
        checkOutput("rsp rdata", coreRdata, e.data);
        checkOutput("rsp err", 32'(coreErr), 32'(e.err));
      end
    end else begin
      checkOutput("idle rdata/err", {coreRdata[31:1], coreRdata[0] | coreErr}, 32'd0);
    end
  end

  task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [3:0] be,
                               input logic [31:0] wdata);
    @(posedge clk);
    #1;
    coreReq = 1'b1; coreAddr = addr; coreWe = we; coreBe = be; coreWdata = wdata;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      coreReq = 1'b0;
    end
  endtask

  logic [31:0] edgeAddr[5];
  tgt_t        edgeTgt[5];

  initial begin
    edgeAddr = '{32'h3000_1FFC, 32'h3000_2000, 32'h7EFF_FFFC, 32'h7F00_0000, 32'h2FFF_FFFC};
    edgeTgt  = '{T_SRAM, T_ERR, T_AXI, T_ERR, T_ERR};
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // SRAM read answered next cycle
    @(negedge clk);
    forceEn = 1'b1; forceData = 32'hDEAD_BEEF; forceErr = 1'b0;
    applyStimulus(32'h3000_0010, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t1 gnt", 32'(coreGnt), 32'd1);
    checkOutput("t1 sram_req", 32'(sramReq), 32'd1);
    checkOutput("t1 axi_req", 32'(axiReq), 32'd0);
    idle(1);
    @(negedge clk);
    checkOutput("t1 rvalid", 32'(coreRvalid), 32'd1);
    checkOutput("t1 rdata", coreRdata, 32'hDEAD_BEEF);
    checkOutput("t1 err", 32'(coreErr), 32'd0);

    // AXI write with error response
    forceData = 32'd0; forceErr = 1'b1;
    applyStimulus(32'h7100_0004, 1'b1, 4'hF, 32'hCAFE_0001);
    @(negedge clk);
    checkOutput("t2 axi_req", 32'(axiReq), 32'd1);
    checkOutput("t2 sram_req", 32'(sramReq), 32'd0);
    checkOutput("t2 gnt", 32'(coreGnt), 32'd1);
    idle(1);
    @(negedge clk);
    checkOutput("t2 rvalid", 32'(coreRvalid), 32'd1);
    checkOutput("t2 err", 32'(coreErr), 32'd1);

    // Unmapped address answered locally
    forceEn = 1'b0;
    applyStimulus(32'h0000_0000, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t3 gnt", 32'(coreGnt), 32'd1);
    checkOutput("t3 target reqs", 32'({sramReq, axiReq}), 32'd0);
    idle(1);
    @(negedge clk);
    checkOutput("t3 rvalid", 32'(coreRvalid), 32'd1);
    checkOutput("t3 err", 32'(coreErr), 32'd1);
    checkOutput("t3 rdata", coreRdata, 32'd0);

    for (int i = 0; i < 5; i++) begin
      applyStimulus(edgeAddr[i], 1'b0, 4'hF, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("t4 sram_req @%08h", edgeAddr[i]), 32'(sramReq), 32'(edgeTgt[i] == T_SRAM));
      checkOutput($sformatf("t4 axi_req @%08h", edgeAddr[i]), 32'(axiReq), 32'(edgeTgt[i] == T_AXI));
      checkOutput($sformatf("t4 gnt @%08h", edgeAddr[i]), 32'(coreGnt), 32'd1);
      idle(2);
    end

    // Outstanding limit and no target mixing
    @(negedge clk);
    rspPct = 0;
    applyStimulus(32'h3000_0100, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t5 first gnt", 32'(coreGnt), 32'd1);
    applyStimulus(32'h3000_0104, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t5 second gnt", 32'(coreGnt), 32'd1);
    applyStimulus(32'h3000_0108, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t5 third stalled", 32'(coreGnt), 32'd0);
    applyStimulus(32'h4000_0040, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t5 axi stalled", 32'({coreGnt, axiReq}), 32'd0);
    rspPct = 100;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("t5 axi gnt cycle %0d", k), 32'(coreGnt), 32'(k == 3));
    end
    idle(3);

    // Reset abandons in-flight work; late responses are ignored
    @(negedge clk);
    rspPct = 0;
    applyStimulus(32'h3000_0200, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t6 gnt a", 32'(coreGnt), 32'd1);
    applyStimulus(32'h3000_0204, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t6 gnt b", 32'(coreGnt), 32'd1);
    @(posedge clk);
    #1;
    coreReq = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    lateInject = 1'b1;
    @(negedge clk);
    checkOutput("t6 late rvalid ignored", 32'(coreRvalid), 32'd0);
    lateInject = 1'b0;
    rspPct = 100;
    applyStimulus(32'h3000_0300, 1'b0, 4'hF, 32'd0);
    @(negedge clk);
    checkOutput("t6 gnt after reset", 32'(coreGnt), 32'd1);
    idle(3);

    // Randomized traffic
    @(negedge clk);
    gntPct = 60;
    rspPct = 50;
    begin
      int  holdCycles = 0;
      bit  granted = 1'b1;
      for (int c = 0; c < 1500; c++) begin
        @(posedge clk);
        #1;
        if (coreReq && !granted) begin
          holdCycles++;
          if (holdCycles > 200) begin
            checks++;
            errors++;
            $display("[TB] FAIL request stuck: waited %0d cycles for gnt, required <= 200", holdCycles);
            coreReq = 1'b0;
            holdCycles = 0;
          end
        end else begin
          holdCycles = 0;
          coreReq   = ($urandom_range(0, 3) != 0);
          coreAddr  = randAddr();
          coreWe    = 1'($urandom);
          coreBe    = 4'($urandom);
          coreWdata = $urandom;
        end
        @(negedge clk);
        granted = coreReq && coreGnt;
      end
    end
    @(posedge clk);
    #1 coreReq = 1'b0;
    @(negedge clk);
    rspPct = 100;
    for (int w = 0; w < 50 && sbQ.size() != 0; w++) @(negedge clk);
    checkOutput("drain scoreboard empty", 32'(sbQ.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
